// File: rtl/speed_meas_pkg.sv
// Shared constants and helpers for the speed measurement blocks.
// Contents: default parameter values, a ceil-log2 constant function and the
// running-sum width derivation used by speed_meas_avg.
package speed_meas_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefAvgDepth = 8;
  localparam int unsigned DefPulses   = 4;
  localparam int unsigned DefFilter   = 500;
  localparam int unsigned DefTimeout  = 50000000;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

  // AVG_DEPTH samples of WIDTH bits each can never overflow this width.
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned depth);
    return width + clog2(depth);
  endfunction

endpackage

// File: rtl/sig_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer.
// The output only follows the synchronised input after it has disagreed with
// the output for FILTER consecutive clocks; any agreeing clock restarts the run.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_in     raw asynchronous input
//   o_out    synchronised, debounced level
module sig_debounce
  import speed_meas_pkg::*;
#(
  parameter int unsigned FILTER = DefFilter
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_out
);

  localparam int unsigned CntW = clog2(FILTER) + 1;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_out;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_out   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_out) begin
        r_cnt <= '0;
      end else if (r_cnt == CntW'(FILTER - 1)) begin
        r_out <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/speed_meas_avg.sv
// Period measurement with running-sum moving average.
// Counts clock cycles spanned by PULSES debounced rising edges of i_in, or
// forces a TIMEOUT sample when the input stalls, and averages the last
// AVG_DEPTH accepted samples.
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_in          raw asynchronous pulse input
//   i_clr         synchronous clear of the averaging window (one-cycle pulse)
//   o_sample      last raw period sample
//   o_sample_vld  one-cycle strobe, o_sample updated
//   o_speed       averaged period in clock cycles
//   o_speed_vld   one-cycle strobe, o_speed updated
//   o_filled      window holds AVG_DEPTH samples
//   o_stall       last sample was a timeout sample
module speed_meas_avg
  import speed_meas_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned AVG_DEPTH = DefAvgDepth,
  parameter int unsigned PULSES    = DefPulses,
  parameter int unsigned FILTER    = DefFilter,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_sample,
  output logic             o_sample_vld,
  output logic [WIDTH-1:0] o_speed,
  output logic             o_speed_vld,
  output logic             o_filled,
  output logic             o_stall
);

  localparam int unsigned LogDepth = clog2(AVG_DEPTH);
  localparam int unsigned SumW     = sum_width(WIDTH, AVG_DEPTH);
  localparam int unsigned EdgeW    = clog2(PULSES) + 1;
  localparam int unsigned FillW    = LogDepth + 1;
  localparam logic [WIDTH-1:0] CntMax = '1;

  logic                w_db;
  logic                w_edge;
  logic                w_edge_sample;
  logic                w_timeout_sample;
  logic                w_sample_evt;
  logic                w_accept;
  logic                w_full;

  logic                r_db_prev;
  logic [WIDTH-1:0]    r_cnt;
  logic [EdgeW-1:0]    r_edge_cnt;
  logic                r_discard;
  logic                r_stall;
  logic [WIDTH-1:0]    r_buf [AVG_DEPTH];
  logic [SumW-1:0]     r_sum;
  logic [LogDepth-1:0] r_wp;
  logic [FillW-1:0]    r_fill;
  logic [WIDTH-1:0]    r_sample;
  logic                r_sample_vld;
  logic [WIDTH-1:0]    r_speed;
  logic                r_speed_vld;

  sig_debounce #(
    .FILTER(FILTER)
  ) u_debounce (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_in   (i_in),
    .o_out  (w_db)
  );

  always_comb begin
    w_edge           = w_db & ~r_db_prev;
    w_edge_sample    = w_edge && (r_edge_cnt == EdgeW'(PULSES - 1));
    // An edge sample in the same cycle takes precedence over the timeout.
    w_timeout_sample = !w_edge_sample && (r_cnt == WIDTH'(TIMEOUT));
    w_sample_evt     = w_edge_sample || w_timeout_sample;
    w_accept         = w_sample_evt && !r_discard && !i_clr;
    w_full           = (r_fill == FillW'(AVG_DEPTH));
  end

  // Event detection: period counter, edge counter, discard and stall flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_prev  <= 1'b0;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_discard  <= 1'b1;
      r_stall    <= 1'b0;
    end else begin
      r_db_prev <= w_db;
      if (i_clr) begin
        r_cnt      <= WIDTH'(1);
        r_edge_cnt <= '0;
        r_discard  <= 1'b1;
        r_stall    <= 1'b0;
      end else if (w_sample_evt) begin
        // Discarded samples still restart the period and clear the discard flag.
        r_cnt      <= WIDTH'(1);
        r_edge_cnt <= '0;
        r_discard  <= 1'b0;
        r_stall    <= w_timeout_sample;
      end else begin
        if (r_cnt != CntMax) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_edge) begin
          r_edge_cnt <= r_edge_cnt + 1'b1;
        end
      end
    end
  end

  // Ring buffer, running sum and output pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(AVG_DEPTH); i++) begin
        r_buf[i] <= '0;
      end
      r_sum        <= '0;
      r_wp         <= '0;
      r_fill       <= '0;
      r_sample     <= '0;
      r_sample_vld <= 1'b0;
      r_speed      <= '0;
      r_speed_vld  <= 1'b0;
    end else begin
      r_sample_vld <= w_accept;
      r_speed_vld  <= 1'b0;
      if (i_clr) begin
        // Empty slots must read zero so the running sum stays exact on refill.
        for (int i = 0; i < int'(AVG_DEPTH); i++) begin
          r_buf[i] <= '0;
        end
        r_sum   <= '0;
        r_wp    <= '0;
        r_fill  <= '0;
        r_speed <= '0;
      end else begin
        if (w_accept) begin
          r_sample    <= r_cnt;
          r_buf[r_wp] <= r_cnt;
          r_sum       <= r_sum + SumW'(r_cnt) - SumW'(r_buf[r_wp]);
          r_wp        <= r_wp + 1'b1;  // power-of-two depth wraps naturally
          if (!w_full) begin
            r_fill <= r_fill + 1'b1;
          end
        end
        if (r_sample_vld && w_full) begin
          r_speed     <= r_sum[SumW-1:LogDepth];
          r_speed_vld <= 1'b1;
        end
      end
    end
  end

  assign o_sample     = r_sample;
  assign o_sample_vld = r_sample_vld;
  assign o_speed      = r_speed;
  assign o_speed_vld  = r_speed_vld;
  assign o_filled     = w_full;
  assign o_stall      = r_stall;

endmodule

// File: tb/tb_speed_meas_avg.sv
// Self-checking bench for speed_meas_avg: directed phases with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model built from cycle timestamps and a sample queue.
module tb_speed_meas_avg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned AVG_DEPTH = 4;
  localparam int unsigned PULSES    = 2;
  localparam int unsigned FILTER    = 3;
  localparam int unsigned TIMEOUT   = 1000;
  localparam int          CntMax    = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_sig = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] sample;
  logic             sample_vld;
  logic [WIDTH-1:0] speed;
  logic             speed_vld;
  logic             filled;
  logic             stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  speed_meas_avg #(
    .WIDTH    (WIDTH),
    .AVG_DEPTH(AVG_DEPTH),
    .PULSES   (PULSES),
    .FILTER   (FILTER),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in        (in_sig),
    .i_clr       (clr),
    .o_sample    (sample),
    .o_sample_vld(sample_vld),
    .o_speed     (speed),
    .o_speed_vld (speed_vld),
    .o_filled    (filled),
    .o_stall     (stall)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is the input seen at the latest clock edge; the synchroniser makes
  // the debouncer look at values two edges older.
  bit   hist [8];
  bit   m_active, m_db, m_discard, m_pend;
  int   m_k, m_last, m_ecnt, m_pend_val;
  int   m_win[$];
  int   e_sample, e_speed;
  bit   e_sample_vld, e_speed_vld, e_filled, e_stall;

  task automatic model_reset();
    foreach (hist[i]) hist[i] = 1'b0;
    m_active = 0; m_db = 0; m_discard = 1; m_pend = 0;
    m_k = 0; m_last = -1; m_ecnt = 0; m_pend_val = 0;
    m_win.delete();
    e_sample = 0; e_speed = 0; e_sample_vld = 0; e_speed_vld = 0; e_filled = 0; e_stall = 0;
  endtask

  // Evaluate everything that happens in cycle c; results are the outputs of cycle c+1.
  task automatic model_cycle(input int c, input bit clr_c);
    bit all_diff, ev, esamp, tsamp;
    int cnt, sum;
    all_diff = 1;
    for (int j = 0; j < int'(FILTER); j++) if (hist[3+j] == m_db) all_diff = 0;
    ev   = all_diff && !m_db;
    if (all_diff) m_db = !m_db;
    cnt  = c - m_last;
    if (cnt > CntMax) cnt = CntMax;
    e_sample_vld = 0;
    e_speed_vld  = 0;
    if (clr_c) begin
      m_win.delete(); m_ecnt = 0; e_speed = 0; e_stall = 0; m_discard = 1; m_last = c;
      m_pend = 0;
    end else begin
      if (m_pend) begin
        e_speed = m_pend_val; e_speed_vld = 1; m_pend = 0;
      end
      esamp = 0; tsamp = 0;
      if (ev) begin
        m_ecnt++;
        if (m_ecnt == int'(PULSES)) begin esamp = 1; m_ecnt = 0; end
      end
      if (!esamp && cnt == int'(TIMEOUT)) begin tsamp = 1; m_ecnt = 0; end
      if (esamp || tsamp) begin
        m_last  = c;
        e_stall = tsamp;
        if (m_discard) m_discard = 0;
        else begin
          e_sample = cnt; e_sample_vld = 1;
          m_win.push_back(cnt);
          if (m_win.size() > int'(AVG_DEPTH)) void'(m_win.pop_front());
          if (m_win.size() == int'(AVG_DEPTH)) begin
            sum = 0;
            foreach (m_win[i]) sum += m_win[i];
            m_pend = 1; m_pend_val = sum / int'(AVG_DEPTH);
          end
        end
      end
    end
    e_filled = (m_win.size() == int'(AVG_DEPTH));
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in_sig;
      if (m_active) model_cycle(m_k - 1, clr);
      m_active = 1;
      m_k++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && m_active) begin
      check("sample_vld", sample_vld, e_sample_vld);
      check("sample", sample, e_sample);
      check("speed_vld", speed_vld, e_speed_vld);
      check("speed", speed, e_speed);
      check("filled", filled, e_filled);
      check("stall", stall, e_stall);
    end
  end

  // ---------------- strobe logger for literal checks ----------------
  int mon_acc = 0;
  int mon_first = -1;
  int speed_log[$];
  int sample_log[$];
  bit stall_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (speed_vld) begin
        if (mon_first < 0) mon_first = mon_acc;
        speed_log.push_back(int'(speed));
      end
      if (sample_vld) begin
        mon_acc++;
        sample_log.push_back(int'(sample));
        stall_log.push_back(stall);
      end
    end
  end

  task automatic log_clear();
    mon_acc = 0; mon_first = -1;
    speed_log.delete(); sample_log.delete(); stall_log.delete();
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    repeat (n) begin
      in_sig = 1'b1; cyc(hi);
      in_sig = 1'b0; cyc(lo);
    end
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_sample_vld"}, sample_vld, 0);
    check({tag, "_speed"}, speed, 0);
    check({tag, "_speed_vld"}, speed_vld, 0);
    check({tag, "_filled"}, filled, 0);
    check({tag, "_stall"}, stall, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1; cyc(1); clr = 1'b0;
  endtask

  task automatic random_run(input int segs);
    int len;
    repeat (segs) begin
      in_sig = ~in_sig;
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(800, 1300))
                                         : int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) begin
        clr = ($urandom_range(0, 299) == 0);
        cyc(1);
      end
      clr = 1'b0;
    end
  endtask

  initial begin
    // Reset held with the input toggling.
    for (int i = 0; i < 10; i++) begin
      in_sig = ~in_sig;
      cyc(1);
    end
    check_zero("reset");
    cyc(1);
    in_sig = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // Debounce: a 2-cycle glitch is filtered, a 3-cycle pulse is an edge.
    in_sig = 1'b1; cyc(2); in_sig = 1'b0; cyc(20);
    in_sig = 1'b1; cyc(3); in_sig = 1'b0; cyc(20);

    // Steady period 100 then step to period 50, from a clean window.
    do_clr();
    log_clear();
    pulses(11, 50, 50);
    pulses(10, 25, 25);
    cyc(10);
    check("steady_first_speed_after", mon_first, 4);
    check("step_speed_count", speed_log.size(), 6);
    if (speed_log.size() == 6) begin
      check("speed_seq0", speed_log[0], 200);
      check("speed_seq1", speed_log[1], 200);
      check("speed_seq2", speed_log[2], 175);
      check("speed_seq3", speed_log[3], 150);
      check("speed_seq4", speed_log[4], 125);
      check("speed_seq5", speed_log[5], 100);
    end
    if (sample_log.size() > 0) check("steady_sample0", sample_log[0], 200);
    check("step_last_sample", sample, 100);
    check("step_filled", filled, 1);

    // Clear while filled.
    do_clr();
    @(negedge clk);
    check("clr_speed", speed, 0);
    check("clr_filled", filled, 0);
    log_clear();
    pulses(10, 30, 30);
    cyc(10);
    check("clr_refill_first_speed_after", mon_first, 4);
    check("clr_refill_speed", speed, 120);

    // Timeout with the input held low, then resume.
    log_clear();
    in_sig = 1'b0;
    cyc(3500);
    check("timeout_count_ge3", (sample_log.size() >= 3), 1);
    for (int i = 0; i < 3 && i < sample_log.size(); i++) begin
      check("timeout_sample", sample_log[i], TIMEOUT);
      check("timeout_stall", stall_log[i], 1);
    end
    check("timeout_stall_level", stall, 1);
    pulses(6, 30, 30);
    cyc(10);
    check("resume_stall", stall, 0);

    // Randomized traffic with sporadic clears, a mid-run reset, more traffic.
    random_run(250);
    rst_n = 1'b0;
    cyc(3);
    check_zero("midreset");
    cyc(1);
    in_sig = 1'b0;
    rst_n = 1'b1;
    random_run(150);
    cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/speed_meas_avg.md
Name: speed_meas_avg

Overview:
Parametrised successor of the single-channel speed measurement block. It takes one raw encoder/tacho input and synchronises and debounces it. It measures the clock cycles spanned by PULSES input edges and smooths the result with a true running-sum moving average of power-of-two depth. Added over the previous generation: async reset, data-valid strobes, stall/timeout flag, window-filled flag, synchronous clear, and raw per-sample output; feeds the motor control loop.

Parameters:
WIDTH, 32, bit width of period counter, samples and SPEED
AVG_DEPTH, 8, moving-average window in samples; power of two, 2..64
PULSES, 4, filtered rising edges per sample
FILTER, 500, debounce length in clocks; 1..4095
TIMEOUT, 50000000, cycles without a sample before a forced timeout sample; < 2^WIDTH-1

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
IN  in  1  raw asynchronous pulse input
CLR  in  1  synchronous clear of average window (pulse)
SAMPLE  out  WIDTH  last raw period sample (cycles per PULSES edges)
SAMPLE_VLD  out  1  one-cycle strobe, SAMPLE updated
SPEED  out  WIDTH  averaged period in clock cycles
SPEED_VLD  out  1  one-cycle strobe, SPEED updated
FILLED  out  1  window holds AVG_DEPTH samples
STALL  out  1  last sample was a timeout sample

Behaviour:
- Reset (RESET_N low, async): all outputs 0, buffer, sum, counters, pointers, fill count 0; discard flag set.
- IN passes through a 2-FF synchroniser, then the debouncer. The debouncer output toggles only after the synchronised input differs from it for FILTER consecutive clocks; any agreeing cycle restarts the run. A rising edge of the debounced signal is an edge event, registered one cycle.
- Period counter cnt: +1 per clock, saturating at 2^WIDTH-1. Set to 1 on a sample event. The sample value is cnt at the event cycle, i.e. the cycle distance between consecutive events.
- Edge counter: +1 per edge event. Reaching PULSES produces an edge sample and clears the counter to 0.
- Timeout: cnt == TIMEOUT with no edge sample that cycle gives a timeout sample (value TIMEOUT), clears the edge counter, and sets STALL. An edge sample sets STALL=0. Edge and timeout in the same cycle: the edge wins.
- The first sample after reset or CLR spans a partial window. It is discarded: no SAMPLE_VLD and no buffer write. cnt is still reset.
- Accepted sample at cycle N:
  - N+1: SAMPLE and SAMPLE_VLD=1.
  - Ring buffer at pointer wp takes the new value; sum <= sum + new - buf[wp]; wp wraps at AVG_DEPTH; fill count saturates at AVG_DEPTH.
  - Sum width is WIDTH+log2(AVG_DEPTH), with no overflow possible.
- N+2: if fill count == AVG_DEPTH, SPEED <= sum >> log2(AVG_DEPTH) (truncating) and SPEED_VLD=1. Otherwise SPEED is unchanged and SPEED_VLD=0. FILLED = (fill count == AVG_DEPTH).
- Samples arrive at most once per PULSES*FILTER cycles, so the pipeline never overlaps. Back-to-back samples (FILTER=1, PULSES=1) must still be handled: one per cycle, in order.
- CLR (sync, one cycle):
  - Clears buffer, sum, wp, fill count, edge counter, SPEED, FILLED and STALL; sets the discard flag; cnt <= 1.
  - An in-flight sample in the same cycle is dropped.
  - CLR has priority over all events.
- Reset mid-operation: immediate return to reset state; no strobes until the discard rule and refill complete.

Decomposition:
- Package speed_meas_pkg: clog2 constant function, default parameter constants, sum-width derivation.
- Sub-module sig_debounce (synchroniser + FILTER debounce, parameter FILTER, ports CLK, RESET_N, IN, OUT). Reused by other encoder inputs.
- Everything else in speed_meas_avg.

Test Plan:
- Reset: hold RESET_N=0 with IN toggling -> all outputs 0; release -> no strobe before the second edge sample.
- Debounce, with FILTER=3: 2-cycle high glitch -> no edge event; 3-cycle high pulse -> edge event 2+3 cycles after the IN rise (sync plus filter).
- Steady rate, with WIDTH=16, AVG_DEPTH=4, PULSES=2, FILTER=3, input period 100 cycles -> SAMPLE=200 each strobe; first SPEED_VLD after the 4th accepted sample with SPEED=200, FILLED=1.
- Step, period 100 -> 50 -> samples 100; SPEED sequence 175, 150, 125, 100 on consecutive SPEED_VLD.
- Timeout, TIMEOUT=1000, IN held low -> SAMPLE=1000, STALL=1 every 1000 cycles; resume pulses -> first edge sample clears STALL.
- CLR while FILLED=1 -> SPEED=0, FILLED=0 next cycle; next sample discarded; SPEED_VLD returns only after 4 further samples.
